// File: rtl/uart_fb_loader.sv
// UART byte-stream loader for the 80x60 RRRGGGBB video buffer: 8N1 receiver,
// command parser (SETPOS / WRITE / FILL), auto-incrementing cursor and fill engine.
module uart_fb_loader #(
    parameter int CLK_HZ = 36000000,
    parameter int BAUD   = 115200,
    parameter int FB_W   = 80,
    parameter int FB_H   = 60,
    parameter int XW     = $clog2(FB_W),
    parameter int YW     = $clog2(FB_H)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RX,
    output logic          fb_we,
    output logic [XW-1:0] fb_x,
    output logic [YW-1:0] fb_y,
    output logic [7:0]    fb_data,
    output logic          busy,
    output logic          frame_err,
    output logic          cmd_err
);
    // Exact halves round down, so 312.5 at the default rates gives 312.
    localparam int DIV  = (CLK_HZ + BAUD / 2 - 1) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int TW   = $clog2(DIV + 1);
    localparam logic [XW-1:0] X_MAX = XW'(FB_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(FB_H - 1);

    // ---------------- receiver ----------------
    logic rx_m, rx_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_t;

    rx_st_t        r_st, r_nxt;
    logic [TW-1:0] tmr, tmr_n;
    logic [2:0]    bitc, bitc_n;
    logic [7:0]    sh, sh_n;
    logic          byte_vld, byte_vld_n, ferr_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_st      <= R_IDLE;
            tmr       <= '0;
            bitc      <= '0;
            sh        <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_st      <= r_nxt;
            tmr       <= tmr_n;
            bitc      <= bitc_n;
            sh        <= sh_n;
            byte_vld  <= byte_vld_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        r_nxt      = r_st;
        tmr_n      = tmr;
        bitc_n     = bitc;
        sh_n       = sh;
        byte_vld_n = 1'b0;
        ferr_n     = 1'b0;
        case (r_st)
            R_IDLE: begin
                if (!rx_s) begin
                    r_nxt = R_START;
                    tmr_n = '0;
                end
            end
            R_START: begin
                // Line back high at mid start bit means a glitch, not a frame.
                if (tmr == TW'(HALF - 1)) begin
                    tmr_n  = '0;
                    bitc_n = '0;
                    r_nxt  = rx_s ? R_IDLE : R_DATA;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            R_DATA: begin
                if (tmr == TW'(DIV - 1)) begin
                    tmr_n = '0;
                    sh_n  = {rx_s, sh[7:1]};
                    if (bitc == 3'd7) r_nxt = R_STOP;
                    else              bitc_n = bitc + 3'd1;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            R_STOP: begin
                if (tmr == TW'(DIV - 1)) begin
                    tmr_n = '0;
                    if (rx_s) begin
                        byte_vld_n = 1'b1;
                        r_nxt      = R_IDLE;
                    end else begin
                        ferr_n = 1'b1;
                        r_nxt  = R_WAIT;
                    end
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            R_WAIT:  if (rx_s) r_nxt = R_IDLE;
            default: r_nxt = R_IDLE;
        endcase
    end

    // ---------------- parser / cursor / fill ----------------
    typedef enum logic [2:0] {P_IDLE, P_OP, P_SX, P_SY, P_CNT, P_PIX, P_FCOL, P_FILL} p_st_t;

    p_st_t         p_st, p_nxt;
    logic [XW-1:0] cur_x, cur_x_n, set_x, set_x_n, fb_x_n;
    logic [YW-1:0] cur_y, cur_y_n, fb_y_n;
    logic [8:0]    cnt, cnt_n;
    logic [7:0]    fb_data_n;
    logic          fb_we_n, busy_n, cmd_err_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_st    <= P_IDLE;
            cur_x   <= '0;
            cur_y   <= '0;
            set_x   <= '0;
            cnt     <= '0;
            fb_we   <= 1'b0;
            fb_x    <= '0;
            fb_y    <= '0;
            fb_data <= '0;
            busy    <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            p_st    <= p_nxt;
            cur_x   <= cur_x_n;
            cur_y   <= cur_y_n;
            set_x   <= set_x_n;
            cnt     <= cnt_n;
            fb_we   <= fb_we_n;
            fb_x    <= fb_x_n;
            fb_y    <= fb_y_n;
            fb_data <= fb_data_n;
            busy    <= busy_n;
            cmd_err <= cmd_err_n;
        end
    end

    always_comb begin
        p_nxt     = p_st;
        cur_x_n   = cur_x;
        cur_y_n   = cur_y;
        set_x_n   = set_x;
        cnt_n     = cnt;
        fb_we_n   = 1'b0;
        fb_x_n    = fb_x;
        fb_y_n    = fb_y;
        fb_data_n = fb_data;
        busy_n    = busy;
        cmd_err_n = 1'b0;
        case (p_st)
            P_IDLE: if (byte_vld && sh == 8'hA5) p_nxt = P_OP;
            P_OP: begin
                if (byte_vld) begin
                    case (sh)
                        8'h01:   p_nxt = P_SX;
                        8'h02:   p_nxt = P_CNT;
                        8'h03:   p_nxt = P_FCOL;
                        default: begin
                            cmd_err_n = 1'b1;
                            p_nxt     = P_IDLE;
                        end
                    endcase
                end
            end
            P_SX: begin
                if (byte_vld) begin
                    set_x_n = (int'(sh) >= FB_W) ? X_MAX : XW'(sh);
                    p_nxt   = P_SY;
                end
            end
            P_SY: begin
                if (byte_vld) begin
                    cur_x_n = set_x;
                    cur_y_n = (int'(sh) >= FB_H) ? Y_MAX : YW'(sh);
                    p_nxt   = P_IDLE;
                end
            end
            P_CNT: begin
                if (byte_vld) begin
                    cnt_n = (sh == 8'h00) ? 9'd256 : {1'b0, sh};
                    p_nxt = P_PIX;
                end
            end
            P_PIX: begin
                if (byte_vld) begin
                    fb_we_n   = 1'b1;
                    fb_x_n    = cur_x;
                    fb_y_n    = cur_y;
                    fb_data_n = sh;
                    if (cur_x == X_MAX) begin
                        cur_x_n = '0;
                        cur_y_n = (cur_y == Y_MAX) ? '0 : cur_y + YW'(1);
                    end else begin
                        cur_x_n = cur_x + XW'(1);
                    end
                    cnt_n = cnt - 9'd1;
                    if (cnt == 9'd1) p_nxt = P_IDLE;
                end
            end
            P_FCOL: begin
                if (byte_vld) begin
                    fb_we_n   = 1'b1;
                    fb_x_n    = '0;
                    fb_y_n    = '0;
                    fb_data_n = sh;
                    busy_n    = 1'b1;
                    p_nxt     = P_FILL;
                end
            end
            P_FILL: begin
                // The output coordinates double as the fill counter.
                if (fb_x == X_MAX && fb_y == Y_MAX) begin
                    busy_n  = 1'b0;
                    cur_x_n = '0;
                    cur_y_n = '0;
                    p_nxt   = P_IDLE;
                end else begin
                    fb_we_n = 1'b1;
                    if (fb_x == X_MAX) begin
                        fb_x_n = '0;
                        fb_y_n = fb_y + YW'(1);
                    end else begin
                        fb_x_n = fb_x + XW'(1);
                    end
                end
                if (byte_vld) cmd_err_n = 1'b1;
            end
            default: p_nxt = P_IDLE;
        endcase
        // A broken frame abandons any half-parsed command; a running fill carries on.
        if (frame_err && p_st != P_FILL) p_nxt = P_IDLE;
    end

endmodule

// File: tb/tb_uart_fb_loader.sv
// Randomized bench for uart_fb_loader: serial stimulus, command-level reference model,
// per-cycle write scoreboard plus literal spot checks.
module tb_uart_fb_loader;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 62500;
    localparam int DIV    = 16;
    localparam int FB_W   = 80;
    localparam int FB_H   = 60;
    localparam int NPIX   = FB_W * FB_H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       fb_we, busy, frame_err, cmd_err;
    logic [6:0] fb_x;
    logic [5:0] fb_y;
    logic [7:0] fb_data;

    uart_fb_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FB_W(FB_W), .FB_H(FB_H)) dut (
        .CLK(clk), .RST(rst), .RX(rx), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
        .fb_data(fb_data), .busy(busy), .frame_err(frame_err), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {logic [6:0] x; logic [5:0] y; logic [7:0] d;} wr_t;

    wr_t        exp_q[$];
    logic [7:0] cmd[$];
    int         mx = 0, my = 0;
    int         fill_end = 0;
    int         cerr_exp = 0, ferr_exp = 0;

    function automatic void push_wr(input int x, input int y, input int d);
        wr_t w;
        w.x = 7'(x);
        w.y = 6'(y);
        w.d = 8'(d);
        exp_q.push_back(w);
    endfunction

    // Called when a byte starts; it completes about 10 bit times later.
    function automatic void model_rx(input logic [7:0] b, input bit ok);
        int idx, n;
        bit in_fill;
        in_fill = (cyc + 10 * DIV) < fill_end;
        if (!ok) begin
            ferr_exp++;
            if (!in_fill) cmd.delete();
            return;
        end
        if (in_fill) begin
            cerr_exp++;
            return;
        end
        cmd.push_back(b);
        if (cmd[0] != 8'hA5) begin
            cmd.delete();
            return;
        end
        if (cmd.size() < 2) return;
        case (cmd[1])
            8'h01: if (cmd.size() == 4) begin
                mx = (cmd[2] >= FB_W) ? FB_W - 1 : int'(cmd[2]);
                my = (cmd[3] >= FB_H) ? FB_H - 1 : int'(cmd[3]);
                cmd.delete();
            end
            8'h02: if (cmd.size() > 3) begin
                n = (cmd[2] == 0) ? 256 : int'(cmd[2]);
                push_wr(mx, my, b);
                idx = (my * FB_W + mx + 1) % NPIX;
                mx  = idx % FB_W;
                my  = idx / FB_W;
                if (cmd.size() - 3 == n) cmd.delete();
            end
            8'h03: if (cmd.size() == 3) begin
                for (int i = 0; i < NPIX; i++) push_wr(i % FB_W, i / FB_W, b);
                fill_end = cyc + 10 * DIV + NPIX + 8;
                mx = 0;
                my = 0;
                cmd.delete();
            end
            default: begin
                cerr_exp++;
                cmd.delete();
            end
        endcase
    endfunction

    // ---------------- compare process ----------------
    wr_t last_wr;
    int  last_we_cyc = 0, run = 0, last_run = 0, busy_cyc = 0;
    int  cerr_seen = 0, ferr_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            run = 0;
        end else begin
            if (fb_we) begin
                wr_t w;
                run++;
                last_wr     = {fb_x, fb_y, fb_data};
                last_we_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL stray_write: got x=%0d y=%0d d=%0h, none expected", fb_x, fb_y, fb_data);
                end else begin
                    w = exp_q.pop_front();
                    check("write_xyd", 32'({fb_x, fb_y, fb_data}), 32'(w));
                end
            end else if (run != 0) begin
                last_run = run;
                run      = 0;
            end
            if (busy) busy_cyc++;
            if (cmd_err) cerr_seen++;
            if (frame_err) ferr_seen++;
        end
    end

    // ---------------- stimulus ----------------
    int stop_mid = 0;

    task automatic send_byte(input logic [7:0] b, input bit ok = 1'b1);
        model_rx(b, ok);
        @(negedge clk) rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = ok;
        stop_mid = cyc + DIV / 2;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat ($urandom_range(2, 20)) @(negedge clk);
    endtask

    task automatic setpos(input logic [7:0] x, input logic [7:0] y);
        send_byte(8'hA5); send_byte(8'h01); send_byte(x); send_byte(y);
    endtask

    task automatic phase_end(input string name);
        repeat (2 * DIV) @(negedge clk);
        check({name, "_pending_writes"}, exp_q.size(), 0);
        check({name, "_cmd_err_pulses"}, cerr_seen, cerr_exp);
        check({name, "_frame_err_pulses"}, ferr_seen, ferr_exp);
    endtask

    task automatic check_zero(input string name);
        check(name, {fb_we, busy, frame_err, cmd_err, fb_x, fb_y, fb_data}, 0);
    endtask

    initial begin
        int b0, bz, d, n, k;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("idle_outputs");

        // 1: SETPOS(5,7) then a one-pixel WRITE
        setpos(8'd5, 8'd7);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'hE3);
        d = last_we_cyc - stop_mid;
        check("t1_last_write", 32'(last_wr), {11'd0, 7'd5, 6'd7, 8'hE3});
        check("t1_latency_in_window", (d >= 1 && d <= DIV), 1);
        phase_end("t1");

        // 2: wrap from the last location to the origin
        setpos(8'd79, 8'd59);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        check("t2_last_write", 32'(last_wr), {11'd0, 7'd0, 6'd0, 8'h22});
        phase_end("t2");

        // 5: bad opcode, then clamped SETPOS
        send_byte(8'hA5); send_byte(8'h7F);
        setpos(8'd200, 8'd200);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h5A);
        check("t5_clamped_write", 32'(last_wr), {11'd0, 7'd79, 6'd59, 8'h5A});
        phase_end("t5");

        // 3: fill, with a byte arriving mid-fill
        b0 = busy_cyc;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h1C);
        send_byte(8'h55);
        k = 0;
        while (busy && k < 6000) begin
            @(negedge clk);
            k++;
        end
        check("t3_fill_finished_in_budget", (k < 6000), 1);
        repeat (4) @(negedge clk);
        check("t3_busy_cycles", busy_cyc - b0, NPIX);
        check("t3_consecutive_writes", last_run, NPIX);
        check("t3_last_fill_write", 32'(last_wr), {11'd0, 7'd79, 6'd59, 8'h1C});
        phase_end("t3");

        // 4: framing error mid-WRITE, then normal traffic
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22, 1'b0);
        setpos(8'd10, 8'd10);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h44);
        check("t4_recovered_write", 32'(last_wr), {11'd0, 7'd10, 6'd10, 8'h44});
        phase_end("t4");

        // random command mix
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    bz = $urandom_range(0, 255);
                    send_byte((bz == 'hA5) ? 8'h5A : 8'(bz));
                end
                1: setpos(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                2: begin
                    n = $urandom_range(1, 4);
                    send_byte(8'hA5); send_byte(8'h02); send_byte(8'(n));
                    for (int j = 0; j < n; j++) send_byte(8'($urandom_range(0, 255)));
                end
                default: begin
                    send_byte(8'hA5);
                    send_byte(8'($urandom_range(4, 255)));
                end
            endcase
        end
        phase_end("random");

        // 6: reset in the middle of WRITE N=5
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h05);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        @(negedge clk) rst = 1'b1;
        cmd.delete();
        mx = 0;
        my = 0;
        fill_end = 0;
        repeat (3) @(negedge clk);
        check_zero("t6_outputs_in_reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("t6_outputs_after_reset");
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h77);
        check("t6_write_at_origin", 32'(last_wr), {11'd0, 7'd0, 6'd0, 8'h77});
        // short low glitch must not start a byte
        @(negedge clk) rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        phase_end("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at %0d, expected finish earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
